// File: rtl/sample_discriminator_config_sequencer_if.sv
// Receive/transmit channel packages and the AXI-stream bundle
// used by the discriminator config sequencer.
package rx_pkg;
  localparam int CHANNELS = 2;
  localparam int SAMPLE_WIDTH = 16;
endpackage

package tx_pkg;
  localparam int CHANNELS = 2;
endpackage

interface Axis_If #(
  parameter int DW = 8
);
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic          last;

  modport master (
    output data, valid, last,
    input  ready
  );

  modport slave (
    input  data, valid, last,
    output ready
  );
endinterface

// File: rtl/sample_discriminator_config_sequencer.sv
// PS-side sequencer: latches one config bundle, streams the selected
// fields to the discriminator, waits, then requests a state reset.
module sample_discriminator_config_sequencer
  import rx_pkg::*;
#(
  parameter int MAX_DELAY_CYCLES = 16,
  parameter int SYNC_CYCLES      = 16,
  parameter int TIMEOUT_CYCLES   = 1024,
  localparam int TIMER_BITS = $clog2(MAX_DELAY_CYCLES),
  localparam int TW = 2 * CHANNELS * SAMPLE_WIDTH,
  localparam int DW = 3 * CHANNELS * TIMER_BITS,
  localparam int SW =
    CHANNELS * $clog2(CHANNELS + tx_pkg::CHANNELS),
  localparam int XW = CHANNELS
) (
  input  logic          ps_clk,
  input  logic          ps_reset,
  input  logic          ps_cfg_valid,
  output logic          ps_cfg_ready,
  input  logic [3:0]    ps_cfg_mask,
  input  logic [TW-1:0] ps_cfg_thresholds,
  input  logic [DW-1:0] ps_cfg_delays,
  input  logic [SW-1:0] ps_cfg_trigger_select,
  input  logic [XW-1:0] ps_cfg_disable,
  Axis_If.master        ps_thresholds,
  Axis_If.master        ps_delays,
  Axis_If.master        ps_trigger_select,
  Axis_If.master        ps_disable_discriminator,
  output logic          ps_reset_state_req,
  output logic          ps_busy,
  output logic          ps_done,
  output logic          ps_error
);

  localparam int CMAX =
    (TIMEOUT_CYCLES > SYNC_CYCLES) ?
    TIMEOUT_CYCLES : SYNC_CYCLES;
  localparam int CW = $clog2(CMAX);

  typedef enum logic [2:0] {
    IDLE,
    SEND_THR,
    SEND_DLY,
    SEND_TRG,
    SEND_DIS,
    SYNC_WAIT,
    RST_REQ
  } state_t;

  state_t        state;
  state_t        nxt;
  state_t        after;
  logic [CW-1:0] cnt;
  logic          cnt_inc;
  logic          err_set;
  logic          load;
  logic          is_send;
  logic          rdy_sel;
  logic          armed;
  logic [3:0]    mask_q;
  logic [TW-1:0] thr_q;
  logic [DW-1:0] dly_q;
  logic [SW-1:0] trg_q;
  logic [XW-1:0] dis_q;

  function automatic state_t first_send(
    input logic [3:0] m
  );
    if (m[0])      return SEND_THR;
    else if (m[1]) return SEND_DLY;
    else if (m[2]) return SEND_TRG;
    else if (m[3]) return SEND_DIS;
    else           return SYNC_WAIT;
  endfunction

  always_comb begin
    nxt     = state;
    after   = SYNC_WAIT;
    cnt_inc = 1'b0;
    err_set = 1'b0;
    load    = 1'b0;
    is_send = 1'b0;
    rdy_sel = 1'b0;
    unique case (state)
      IDLE: begin
        if (ps_cfg_valid && ps_cfg_ready) begin
          load = 1'b1;
          nxt  = first_send(ps_cfg_mask);
        end
      end
      SEND_THR: begin
        is_send = 1'b1;
        rdy_sel = ps_thresholds.ready;
        after   = first_send(mask_q & 4'b1110);
      end
      SEND_DLY: begin
        is_send = 1'b1;
        rdy_sel = ps_delays.ready;
        after   = first_send(mask_q & 4'b1100);
      end
      SEND_TRG: begin
        is_send = 1'b1;
        rdy_sel = ps_trigger_select.ready;
        after   = first_send(mask_q & 4'b1000);
      end
      SEND_DIS: begin
        is_send = 1'b1;
        rdy_sel = ps_disable_discriminator.ready;
        after   = SYNC_WAIT;
      end
      SYNC_WAIT: begin
        if (cnt == CW'(SYNC_CYCLES - 1)) nxt = RST_REQ;
        else cnt_inc = 1'b1;
      end
      RST_REQ: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // a ready on the limit cycle still wins over the timeout
    if (is_send) begin
      if (rdy_sel) begin
        nxt = after;
      end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        nxt     = IDLE;
        err_set = 1'b1;
      end else begin
        cnt_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge ps_clk) begin
    if (ps_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      armed    <= 1'b0;
      ps_error <= 1'b0;
    end else begin
      state <= nxt;
      armed <= 1'b1;
      if (nxt != state) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CW'(1);
      if (load) ps_error <= 1'b0;
      else if (err_set) ps_error <= 1'b1;
    end
  end

  always_ff @(posedge ps_clk) begin
    if (ps_reset) begin
      mask_q <= '0;
    end else if (load) begin
      mask_q <= ps_cfg_mask;
      thr_q  <= ps_cfg_thresholds;
      dly_q  <= ps_cfg_delays;
      trg_q  <= ps_cfg_trigger_select;
      dis_q  <= ps_cfg_disable;
    end
  end

  assign ps_cfg_ready = armed && (state == IDLE);
  assign ps_busy      = (state != IDLE);
  assign ps_reset_state_req = (state == RST_REQ);
  assign ps_done      = (state == RST_REQ);

  assign ps_thresholds.valid = (state == SEND_THR);
  assign ps_thresholds.data  = thr_q;
  assign ps_thresholds.last  = 1'b1;

  assign ps_delays.valid = (state == SEND_DLY);
  assign ps_delays.data  = dly_q;
  assign ps_delays.last  = 1'b1;

  assign ps_trigger_select.valid = (state == SEND_TRG);
  assign ps_trigger_select.data  = trg_q;
  assign ps_trigger_select.last  = 1'b1;

  assign ps_disable_discriminator.valid = (state == SEND_DIS);
  assign ps_disable_discriminator.data  = dis_q;
  assign ps_disable_discriminator.last  = 1'b1;

endmodule
